// File: rtl/dcnn_chain_ctrl.sv
// dcnn_chain_ctrl: job sequencer for a chain of PARA convolution PEs.
// A job loads K*K kernel weights, streams W*R pixel pairs into the chain,
// drains the pipeline for PARA+1 cycles and pulses done.
// Optional feature macro: DCNN_CHAIN_CTRL_PERF_EN adds the stall_cnt output.
module dcnn_chain_ctrl #(
    parameter int unsigned K_BITS = 4,
    parameter int unsigned M_BITS = 10,
    parameter int unsigned PARA   = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [K_BITS-1:0] k_size,
    input  logic [M_BITS-1:0] img_width,
    input  logic [M_BITS-1:0] img_rows,
    input  logic              src_vld,
    output logic              src_rdy,
    output logic              mode_kernel_load,
    output logic [PARA-1:0]   en_flag,
    output logic [PARA-1:0]   en_attribute,
    output logic [1:0]        image_vld,
    output logic              busy,
    output logic              done
`ifdef DCNN_CHAIN_CTRL_PERF_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int unsigned KK_BITS = 2 * K_BITS;
    localparam int unsigned D_BITS  = $clog2(PARA + 1);

    typedef enum logic [2:0] {IDLE, KLOAD, CONV, DRAIN, FIN} state_e;

    state_e              state;
    logic [K_BITS-1:0]   k_reg;
    logic [M_BITS-1:0]   w_reg;
    logic [M_BITS-1:0]   r_reg;
    logic [KK_BITS-1:0]  wt_cnt;
    logic [M_BITS-1:0]   col_cnt;
    logic [M_BITS-1:0]   row_cnt;
    logic [D_BITS-1:0]   drain_cnt;

    logic                hs;
    logic                k_ok;
    logic [KK_BITS-1:0]  kk_last;
    logic [M_BITS-1:0]   w_last;
    logic [M_BITS-1:0]   r_last;

    // Thermometer mask: PEs 0..K-1 take part in the job.
    function automatic logic [PARA-1:0] therm_mask(input logic [K_BITS-1:0] k);
        logic [PARA-1:0] m;
        m = '0;
        for (int i = 0; i < int'(PARA); i++) begin
            m[i] = (i < int'(k));
        end
        return m;
    endfunction

    // Tail marker: the last active PE of the chain.
    function automatic logic [PARA-1:0] tail_mask(input logic [K_BITS-1:0] k);
        return PARA'(1) << (k - K_BITS'(1));
    endfunction

    // Handshake qualifiers and end-of-count compare values.
    assign hs      = src_vld & src_rdy;
    assign k_ok    = (k_size != '0) && (32'(k_size) <= PARA);
    assign kk_last = KK_BITS'(k_reg) * KK_BITS'(k_reg) - KK_BITS'(1);
    assign w_last  = w_reg - M_BITS'(1);
    assign r_last  = r_reg - M_BITS'(1);

    // Pixel-valid is zero latency from the CONV handshake.
    assign image_vld = {2{(state == CONV) & hs}};

    // Job sequencer; registered outputs change together with the state.
    // DRAIN is a fixed cycle count and does not depend on src_vld.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            k_reg            <= '0;
            w_reg            <= '0;
            r_reg            <= '0;
            wt_cnt           <= '0;
            col_cnt          <= '0;
            row_cnt          <= '0;
            drain_cnt        <= '0;
            src_rdy          <= 1'b0;
            mode_kernel_load <= 1'b0;
            en_flag          <= '0;
            en_attribute     <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        k_reg     <= k_size;
                        w_reg     <= img_width;
                        r_reg     <= img_rows;
                        wt_cnt    <= '0;
                        col_cnt   <= '0;
                        row_cnt   <= '0;
                        drain_cnt <= '0;
                        busy      <= 1'b1;
                        if (k_ok) begin
                            state            <= KLOAD;
                            src_rdy          <= 1'b1;
                            mode_kernel_load <= 1'b1;
                            en_flag          <= therm_mask(k_size);
                            en_attribute     <= tail_mask(k_size);
                        end else begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                KLOAD: begin
                    if (hs) begin
                        wt_cnt <= wt_cnt + KK_BITS'(1);
                        if (wt_cnt == kk_last) begin
                            state            <= CONV;
                            mode_kernel_load <= 1'b0;
                        end
                    end
                end
                CONV: begin
                    if (hs) begin
                        if (col_cnt == w_last) begin
                            col_cnt <= '0;
                            row_cnt <= row_cnt + M_BITS'(1);
                            if (row_cnt == r_last) begin
                                state        <= DRAIN;
                                src_rdy      <= 1'b0;
                                en_flag      <= '0;
                                en_attribute <= '0;
                            end
                        end else begin
                            col_cnt <= col_cnt + M_BITS'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == D_BITS'(PARA)) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + D_BITS'(1);
                    end
                end
                FIN: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef DCNN_CHAIN_CTRL_PERF_EN
    // Saturating count of cycles the source starved the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if ((state == IDLE) && start) begin
            stall_cnt <= '0;
        end else if (((state == KLOAD) || (state == CONV)) && !src_vld && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcnn_chain_ctrl.sv
// Bench for dcnn_chain_ctrl: directed and randomized jobs compared each cycle
// against a handshake-count model of the job.
module tb_dcnn_chain_ctrl;

    localparam int K_BITS = 4;
    localparam int M_BITS = 10;
    localparam int PARA   = 9;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [K_BITS-1:0] k_size;
    logic [M_BITS-1:0] img_width;
    logic [M_BITS-1:0] img_rows;
    logic              src_vld;
    logic              src_rdy;
    logic              mode_kernel_load;
    logic [PARA-1:0]   en_flag;
    logic [PARA-1:0]   en_attribute;
    logic [1:0]        image_vld;
    logic              busy;
    logic              done;
`ifdef DCNN_CHAIN_CTRL_PERF_EN
    logic [31:0]       stall_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    dcnn_chain_ctrl #(
        .K_BITS(K_BITS),
        .M_BITS(M_BITS),
        .PARA  (PARA)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .k_size          (k_size),
        .img_width       (img_width),
        .img_rows        (img_rows),
        .src_vld         (src_vld),
        .src_rdy         (src_rdy),
        .mode_kernel_load(mode_kernel_load),
        .en_flag         (en_flag),
        .en_attribute    (en_attribute),
        .image_vld       (image_vld),
        .busy            (busy),
`ifdef DCNN_CHAIN_CTRL_PERF_EN
        .done            (done),
        .stall_cnt       (stall_cnt)
`else
        .done            (done)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack_out(input logic rdy, input logic mode, input logic bsy,
                                             input logic dn, input logic [1:0] iv,
                                             input logic [PARA-1:0] ef, input logic [PARA-1:0] ea);
        return 32'({rdy, mode, bsy, dn, iv, ef, ea});
    endfunction

    function automatic logic [31:0] dut_out();
        return pack_out(src_rdy, mode_kernel_load, busy, done, image_vld, en_flag, en_attribute);
    endfunction

    // pat: 0 = src_vld always 1, 1 = low every 3rd cycle, 2 = random.
    // poke: pulse start with other parameters mid-job.
    // rst_at: >=0 asserts rst at that CONV handshake count.
    task automatic run_job(input int k, input int w, input int r, input int pat,
                           input bit poke, input int rst_at);
        int  kk, px, hs, dr, cyc, stalls, n_kl, n_cv, n_dr, dut_done, limit;
        bit  ok_k, vld, ld, cv, in_dr, fin, stop;
        logic [PARA-1:0] ef_e, ea_e;

        ok_k   = (k >= 1) && (k <= PARA);
        kk     = ok_k ? k * k : 0;
        px     = ok_k ? w * r : 0;
        dr     = ok_k ? 0 : PARA + 1;
        hs     = 0;
        cyc    = 0;
        stalls = 0;
        n_kl   = 0;
        n_cv   = 0;
        n_dr   = 0;
        dut_done = -1;
        limit  = 8 * (kk + px) + PARA + 20;
        stop   = 1'b0;

        @(negedge clk);
        start     = 1'b1;
        k_size    = K_BITS'(k);
        img_width = M_BITS'(w);
        img_rows  = M_BITS'(r);
        src_vld   = 1'b1;
        #1;
        check("idle_before_start", dut_out(), 32'd0);

        @(negedge clk);
        start     = 1'b0;
        k_size    = K_BITS'($urandom);
        img_width = M_BITS'($urandom);
        img_rows  = M_BITS'($urandom);

        while (!stop) begin
            ld    = hs < kk;
            cv    = !ld && (hs < kk + px);
            in_dr = !ld && !cv && (dr < PARA + 1);
            fin   = !ld && !cv && !in_dr;

            case (pat)
                0:       vld = 1'b1;
                1:       vld = (cyc % 3) != 2;
                default: vld = $urandom_range(0, 3) != 0;
            endcase
            src_vld = vld;
            if (poke && cyc == 4) begin
                start     = 1'b1;
                k_size    = K_BITS'($urandom_range(1, PARA));
                img_width = M_BITS'($urandom_range(1, 20));
                img_rows  = M_BITS'($urandom_range(1, 20));
            end else begin
                start = 1'b0;
            end
            if (rst_at >= 0 && cv && (hs - kk) == rst_at) rst = 1'b1;
            #1;

            ef_e = (ld || cv) ? PARA'((1 << k) - 1) : '0;
            ea_e = (ld || cv) ? PARA'(1 << (k - 1)) : '0;
            check($sformatf("outputs k%0d w%0d r%0d cyc%0d", k, w, r, cyc), dut_out(),
                  pack_out(ld || cv, ld, 1'b1, fin, (cv && vld) ? 2'b11 : 2'b00, ef_e, ea_e));

            if (src_rdy && src_vld && mode_kernel_load) n_kl++;
            if (image_vld == 2'b11) n_cv++;
            if (busy && !src_rdy && !done) n_dr++;
            if (done && dut_done < 0) dut_done = cyc;

            if (rst) begin
                @(negedge clk);
                start   = 1'b0;
                src_vld = 1'b1;
                #1;
                check("rst_hold_outputs", dut_out(), 32'd0);
                rst = 1'b0;
                @(negedge clk);
                #1;
                check("rst_after_outputs", dut_out(), 32'd0);
`ifdef DCNN_CHAIN_CTRL_PERF_EN
                check("rst_stall_cnt", stall_cnt, 32'd0);
`endif
                return;
            end

            if ((ld || cv) && vld) hs++;
            if ((ld || cv) && !vld) stalls++;
            if (in_dr) dr++;
            if (fin) begin
                stop = 1'b1;
            end else begin
                cyc++;
                if (cyc > limit) begin
                    check("job_timeout", 32'(cyc), 32'(limit));
                    stop = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
        end

        check("kload_handshakes", 32'(n_kl), 32'(kk));
        check("conv_handshakes", 32'(n_cv), 32'(px));
        check("drain_cycles", 32'(n_dr), ok_k ? 32'(PARA + 1) : 32'd0);
        check("done_cycle", 32'(dut_done), ok_k ? 32'(kk + px + stalls + PARA + 1) : 32'd0);

        @(negedge clk);
        src_vld = 1'b0;
        #1;
        check("idle_after_job", dut_out(), 32'd0);
`ifdef DCNN_CHAIN_CTRL_PERF_EN
        check("stall_cnt", stall_cnt, 32'(stalls));
`endif
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        src_vld   = 1'b0;
        k_size    = '0;
        img_width = '0;
        img_rows  = '0;
        repeat (2) @(negedge clk);
        start   = 1'b1;
        src_vld = 1'b1;
        #1;
        check("reset_outputs", dut_out(), 32'd0);
        @(negedge clk);
        #1;
        check("reset_overrides_start", dut_out(), 32'd0);
        rst     = 1'b0;
        start   = 1'b0;
        src_vld = 1'b0;

        // Basic job, then the same job with periodic starvation.
        run_job(3, 4, 2, 0, 1'b0, -1);
        run_job(3, 4, 2, 1, 1'b0, -1);
        // Illegal kernel sizes skip straight to done.
        run_job(0, 5, 5, 0, 1'b0, -1);
        run_job(10, 5, 5, 0, 1'b0, -1);
        // Full-width chain.
        run_job(9, 2, 2, 2, 1'b0, -1);
        // Smallest job.
        run_job(1, 1, 1, 1, 1'b0, -1);
        // Mid-CONV reset, then a clean job.
        run_job(2, 5, 3, 0, 1'b0, 4);
        run_job(2, 3, 2, 2, 1'b0, -1);
        // Start pulse while busy must not disturb the job.
        run_job(4, 3, 3, 0, 1'b1, -1);
        // Random legal jobs.
        for (int j = 0; j < 4; j++) begin
            run_job($urandom_range(1, PARA), $urandom_range(1, 6),
                    $urandom_range(1, 4), 2, 1'(j % 2), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
